fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter and burst sequencer for the write port of async_fifo.
- Shares the single FIFO write port among NUM_REQ requesters, all in the wr_clk domain.
- Each requester uses a valid/ready handshake. The arbiter drives write_en/data_in and honours fifo_full.
- Sits directly in front of async_fifo on the write side.

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/rr_priority_picker.sv | 13 +
 rtl/fifo_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, stats width and the round-robin search used by the write arbiter.
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, BURST, HOLD} arb_state_t;
  localparam int STATS_WIDTH = 16;
  function automatic int rr_pick(input logic [31:0] valid, input int last, input int n);
    for (int k = 1; k <= n; k++)
      if (((valid >> ((last + k) % n)) & 32'd1) != 32'd0) return (last + k) % n;
    return 0;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first valid index after last, with wrap-around, plus a found flag.
module rr_priority_picker import fifo_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          found
);
  assign idx   = IW'(rr_pick(32'(valid), int'(last), N));
  assign found = |valid;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst sequencer sharing the async_fifo write port.
// Define FIFO_ARB_STATS_EN to add per-requester saturating accepted-word counters (beat_total).
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_LEN  = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                         wr_clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         write_en,
  output logic [DATA_LEN-1:0]          data_in,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_WIDTH-1:0] beat_total
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, owner_n, last_owner, last_n, pick_last, pick;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [NUM_REQ-1:0] pick_valid;
  logic found, own_valid, transfer, release_c;
  assign own_valid = req_valid[owner];
  assign transfer  = state == BURST && own_valid && !fifo_full;
  assign release_c = state != IDLE && (!own_valid || (transfer && beat_cnt == BW'(MAX_BURST - 1)));
  // On release the current owner is masked so a lone requester re-arbitrates through IDLE
  assign pick_valid = state == IDLE ? req_valid : req_valid & ~(NUM_REQ'(1) << owner);
  assign pick_last  = state == IDLE ? last_owner : owner;
  rr_priority_picker #(.N(NUM_REQ)) u_pick (
    .valid(pick_valid),
    .last (pick_last),
    .idx  (pick),
    .found(found)
  );
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    beat_n  = beat_cnt;
    if (state == IDLE) begin
      state_n = found ? BURST : IDLE;
      owner_n = found ? pick : owner;
    end else if (release_c) begin
      last_n  = owner;
      beat_n  = '0;
      state_n = found ? BURST : IDLE;
      owner_n = found ? pick : owner;
    end else if (transfer) begin
      beat_n = beat_cnt + BW'(1);
    end else begin
      state_n = fifo_full ? HOLD : BURST;
    end
  end
  always_ff @(posedge wr_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      beat_cnt   <= beat_n;
    end
  end
  assign write_en  = reset_n && transfer;
  assign req_ready = write_en ? NUM_REQ'(1) << owner : '0;
  assign data_in   = reset_n ? req_data[int'(owner)*DATA_LEN +: DATA_LEN] : '0;
  assign grant_id  = owner;
  assign busy      = state != IDLE;
`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    always_ff @(posedge wr_clk) begin
      if (!reset_n) beat_total[g*STATS_WIDTH +: STATS_WIDTH] <= '0;
      else if (req_ready[g] && beat_total[g*STATS_WIDTH +: STATS_WIDTH] != '1)
        beat_total[g*STATS_WIDTH +: STATS_WIDTH] <= beat_total[g*STATS_WIDTH +: STATS_WIDTH] + STATS_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed checks of fifo_wr_arbiter against a cycle-level spec model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 16, MB = 8;
  logic wr_clk = 0, reset_n = 0, fifo_full = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic write_en, busy;
  logic [W-1:0] data_in;
  logic [1:0] grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] beat_total;
`endif
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_LEN(W), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .write_en(write_en), .data_in(data_in),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .beat_total(beat_total)
`endif
  );
  always #5 wr_clk = ~wr_clk;

  int vecs = 0, errs = 0, cyc = 0;
  logic [W-1:0] q[N][$];
  logic [N-1:0] en;
  int m_owner, m_last, m_beats, stat[N];
  bit m_active, m_hold, chk;
  logic [W-1:0] wr_data[$];
  int wr_cyc[$];

  function automatic int pick(logic [N-1:0] v, int after, int excl);
    for (int k = 1; k <= N; k++) begin
      int i = (after + k) % N;
      if (v[i[1:0]] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] v, rdy;
    logic [W-1:0] exp_d;
    bit we;
    int p;
    for (int i = 0; i < N; i++) begin
      v[i] = en[i] && q[i].size() > 0;
      req_data[i*W +: W] = q[i].size() > 0 ? q[i][0] : W'($urandom);
    end
    req_valid = v;
    #1;
    we = reset_n && m_active && !m_hold && v[m_owner[1:0]] && !fifo_full;
    rdy = we ? N'(1) << m_owner : '0;
    exp_d = we ? q[m_owner][0] : '0;
    if (chk) begin
      vecs += 4;
      if (write_en !== we) begin errs++; $display("FAIL write_en cyc=%0d got %b exp %b", cyc, write_en, we); end
      if (req_ready !== rdy) begin errs++; $display("FAIL req_ready cyc=%0d got %b exp %b", cyc, req_ready, rdy); end
      if (busy !== m_active) begin errs++; $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, m_active); end
      if (grant_id !== 2'(m_owner)) begin errs++; $display("FAIL grant_id cyc=%0d got %0d exp %0d", cyc, grant_id, m_owner); end
      if (we || !reset_n) begin
        vecs++;
        if (data_in !== exp_d) begin errs++; $display("FAIL data_in cyc=%0d got %h exp %h", cyc, data_in, exp_d); end
      end
    end
    if (write_en === 1'b1) begin wr_data.push_back(data_in); wr_cyc.push_back(cyc); end
    if (we) begin void'(q[m_owner].pop_front()); stat[m_owner]++; end
    if (!reset_n) begin
      m_active = 0; m_hold = 0; m_owner = 0; m_last = N - 1; m_beats = 0;
      for (int i = 0; i < N; i++) stat[i] = 0;
    end else if (!m_active) begin
      p = pick(v, m_last, -1);
      if (p >= 0) begin m_active = 1; m_owner = p; end
    end else if (!v[m_owner[1:0]] || (we && m_beats == MB - 1)) begin
      m_last = m_owner; m_beats = 0; m_hold = 0;
      p = pick(v, m_owner, m_owner);
      if (p >= 0) m_owner = p; else m_active = 0;
    end else if (we) m_beats++;
    else m_hold = fifo_full;
    @(posedge wr_clk);
    cyc++;
    @(negedge wr_clk);
  endtask

  task automatic flush_and_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    en = '0; fifo_full = 0;
    reset_n = 0; step(); reset_n = 1;
    wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic check_stats();
`ifdef FIFO_ARB_STATS_EN
    int sum = 0;
    for (int i = 0; i < N; i++) begin
      vecs++; sum += int'(beat_total[i*16 +: 16]);
      if (beat_total[i*16 +: 16] !== 16'(stat[i])) begin errs++; $display("FAIL beat_total[%0d] got %0d exp %0d", i, beat_total[i*16 +: 16], stat[i]); end
    end
    vecs++;
    if (sum != wr_data.size()) begin errs++; $display("FAIL beat_total_sum got %0d exp %0d", sum, wr_data.size()); end
`endif
  endtask

  task automatic test_reset();
    reset_n = 0;
    en = 4'hF;
    for (int i = 0; i < N; i++) q[i].push_back(W'($urandom));
    for (int k = 0; k < 3; k++) step();
    reset_n = 1;
    step();
    flush_and_reset();
  endtask

  task automatic test_single();
    flush_and_reset();
    for (int k = 0; k < 20; k++) q[0].push_back(W'(k));
    en[0] = 1;
    for (int k = 0; k < 26; k++) step();
    vecs++;
    if (wr_data.size() != 20) begin errs++; $display("FAIL single_count got %0d exp 20", wr_data.size()); end
    for (int k = 0; k < 20 && k < wr_data.size(); k++) begin
      int gap = k + (k >= 8 ? 1 : 0) + (k >= 16 ? 1 : 0);
      vecs += 2;
      if (wr_data[k] !== W'(k)) begin errs++; $display("FAIL single_word[%0d] got %0d exp %0d", k, wr_data[k], k); end
      if (wr_cyc[k] - wr_cyc[0] != gap) begin errs++; $display("FAIL single_timing[%0d] got %0d exp %0d", k, wr_cyc[k] - wr_cyc[0], gap); end
    end
  endtask

  task automatic test_fairness();
    flush_and_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 40; k++) q[i].push_back(W'(i * 4096 + k));
    en = 4'hF;
    for (int k = 0; k < 64; k++) step();
    vecs++;
    if (wr_data.size() != 63) begin errs++; $display("FAIL fair_count got %0d exp 63", wr_data.size()); end
    for (int k = 0; k < 40 && k < wr_data.size(); k++) begin
      vecs += 2;
      if (int'(wr_data[k][15:12]) != (k / 8) % N) begin errs++; $display("FAIL fair_src[%0d] got %0d exp %0d", k, wr_data[k][15:12], (k / 8) % N); end
      if (wr_cyc[k] - wr_cyc[0] != k) begin errs++; $display("FAIL fair_bubble[%0d] got %0d exp %0d", k, wr_cyc[k] - wr_cyc[0], k); end
    end
    check_stats();
  endtask

  task automatic test_backpressure();
    int stall = 0;
    flush_and_reset();
    for (int k = 0; k < 8; k++) q[0].push_back(W'(100 + k));
    en[0] = 1;
    for (int k = 0; k < 22; k++) begin
      fifo_full = wr_data.size() == 3 && stall < 5;
      if (fifo_full) stall++;
      step();
    end
    fifo_full = 0;
    vecs += 2;
    if (wr_data.size() != 8) begin errs++; $display("FAIL bp_count got %0d exp 8", wr_data.size()); end
    if (wr_data.size() >= 4 && wr_cyc[3] - wr_cyc[2] != 7) begin errs++; $display("FAIL bp_resume got %0d exp 7", wr_cyc[3] - wr_cyc[2]); end
    for (int k = 0; k < wr_data.size(); k++) begin
      vecs++;
      if (wr_data[k] !== W'(100 + k)) begin errs++; $display("FAIL bp_word[%0d] got %0d exp %0d", k, wr_data[k], 100 + k); end
    end
  endtask

  task automatic test_short_burst(input bit with3);
    int exp_next = with3 ? 3 : 1;
    flush_and_reset();
    for (int k = 0; k < 3; k++) q[2].push_back(W'(2 * 4096 + k));
    for (int k = 0; k < 5; k++) begin q[1].push_back(W'(1 * 4096 + k)); q[3].push_back(W'(3 * 4096 + k)); end
    en[2] = 1;
    for (int k = 0; k < 10 && wr_data.size() == 0; k++) step();
    en[1] = 1; en[3] = with3;
    for (int k = 0; k < 20; k++) step();
    vecs += 2;
    if (wr_data.size() < 4) begin errs++; $display("FAIL short_count got %0d exp >=4", wr_data.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (wr_data[k][15:12] !== 4'd2) begin errs++; $display("FAIL short_src[%0d] got %0d exp 2", k, wr_data[k][15:12]); end
      end
      if (int'(wr_data[3][15:12]) != exp_next) begin errs++; $display("FAIL short_next got %0d exp %0d", wr_data[3][15:12], exp_next); end
    end
  endtask

  task automatic test_reset_mid();
    flush_and_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 20; k++) q[i].push_back(W'(i * 4096 + k));
    en = 4'hF; en[0] = 0;
    for (int k = 0; k < 20 && wr_data.size() < 4; k++) step();
    reset_n = 0; step(); reset_n = 1;
    #1;
    vecs += 3;
    if (wr_data.size() != 4) begin errs++; $display("FAIL rmid_count got %0d exp 4", wr_data.size()); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b exp 0", busy); end
    if (grant_id !== 2'd0) begin errs++; $display("FAIL rmid_grant got %0d exp 0", grant_id); end
    en[0] = 1;
    for (int k = 0; k < 10; k++) step();
    vecs++;
    if (wr_data.size() < 5 || wr_data[4][15:12] !== 4'd0) begin errs++; $display("FAIL rmid_next got %0d exp 0", wr_data.size() < 5 ? -1 : int'(wr_data[4][15:12])); end
  endtask

  task automatic test_random();
    flush_and_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 150; k++) q[i].push_back(W'($urandom));
    for (int k = 0; k < 400; k++) begin
      en = N'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? en : '0);
      fifo_full = $urandom_range(0, 3) == 0;
      step();
    end
    fifo_full = 0;
    check_stats();
  endtask

  initial begin
    chk = 0;
    en = '0;
    reset_n = 0;
    step(); step();
    chk = 1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_short_burst(0);
    test_short_burst(1);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
